// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//
// Registered binary-to-one-hot (or one-cold) decoder with an optional
// auto-scan mode. In direct mode the index register is loaded from sel on a
// load strobe. In scan mode the index advances by one every DIV enabled clock
// cycles, and a one-cycle wrap pulse flags the step from the last index back
// to 0.
//
// Parameters
//   SEL_W   : select width (1..6); the output is 2**SEL_W bits wide
//   DIV     : clock cycles per scan step (>= 1)
//   ACT_LOW : 0 -> the active bit is 1, 1 -> the active bit is 0
//
// Ports
//   clk  in   single clock, rising edge
//   rst  in   synchronous active-high reset; has priority over every input
//   en   in   output enable; 0 forces y inactive and freezes idx/cnt
//   mode in   0 = direct decode, 1 = auto-scan
//   load in   strobe capturing sel into the index register (wins over step)
//   sel  in   index to decode, or the scan start point
//   y    out  registered decoded output
//   idx  out  current index register
//   wrap out  one-cycle pulse when the scan steps from 2**SEL_W-1 to 0
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int SEL_W   = 2,
    parameter int DIV     = 4,
    parameter int ACT_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int N     = 2**SEL_W;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};
    localparam logic             ACT      = (ACT_LOW != 0);

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     y_q, y_d;
    logic             wrap_q, wrap_d;
    logic             mode_q;         // mode seen on the previous edge
    logic [N-1:0]     dec_on;         // one-hot decode of the next index

    // Next-state for index, step counter and wrap pulse.
    // Priority inside the enabled case: load > mode change > direct > step.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (en) begin
            if (load) begin
                idx_d = sel;
                cnt_d = '0;
            end else if (mode != mode_q) begin
                // A mode switch restarts the step timing; idx is kept.
                cnt_d = '0;
            end else if (!mode) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                idx_d  = idx_q + SEL_W'(1);
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Decode the index that will be held after this edge so y and idx
    // change together (one-cycle registered latency from the inputs).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign dec_on[gi] = (idx_d == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        y_d = en ? dec_on : '0;
        if (ACT) begin
            y_d = ~y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= {N{ACT}};
            wrap_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
            mode_q <= mode;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan
//
// Two instances of decoder_scan: A uses the defaults (SEL_W=2, DIV=4,
// ACT_LOW=0), B uses SEL_W=3, DIV=1, ACT_LOW=1. Each edge a behavioural
// model per instance is advanced and all outputs are compared; directed
// sequences add constant expectations, then randomized stimulus follows.
// -----------------------------------------------------------------------------
module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       a_rst, a_en, a_mode, a_load;
    logic [1:0] a_sel;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       wrap_a;

    // Instance B signals
    logic       b_rst, b_en, b_mode, b_load;
    logic [2:0] b_sel;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    decoder_scan #(.SEL_W(2), .DIV(4), .ACT_LOW(0)) u_a (
        .clk (clk),
        .rst (a_rst),
        .en  (a_en),
        .mode(a_mode),
        .load(a_load),
        .sel (a_sel),
        .y   (y_a),
        .idx (idx_a),
        .wrap(wrap_a)
    );

    decoder_scan #(.SEL_W(3), .DIV(1), .ACT_LOW(1)) u_b (
        .clk (clk),
        .rst (b_rst),
        .en  (b_en),
        .mode(b_mode),
        .load(b_load),
        .sel (b_sel),
        .y   (y_b),
        .idx (idx_b),
        .wrap(wrap_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance parameters as seen by the model
    int p_selw [2] = '{2, 3};
    int p_div  [2] = '{4, 1};
    int p_al   [2] = '{0, 1};

    // Model state: index, cycles since last step, previous mode,
    // whether the last edge was enabled, and the wrap flag.
    int m_idx  [2];
    int m_cnt  [2];
    int m_prev [2];
    int m_on   [2];
    int m_wrap [2];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model.
    function automatic void model_edge(input int k, input bit r, input bit e,
                                       input bit md, input bit ld, input int s);
        int n;
        n = 1 << p_selw[k];
        if (r) begin
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
            m_prev[k] = 0;
            m_on[k]   = 0;
            m_wrap[k] = 0;
            return;
        end
        m_wrap[k] = 0;
        m_on[k]   = e ? 1 : 0;
        if (e) begin
            if (ld) begin
                m_idx[k] = s;
                m_cnt[k] = 0;
            end else if (int'(md) != m_prev[k] || !md) begin
                m_cnt[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] >= p_div[k]) begin
                    m_cnt[k] = 0;
                    if (m_idx[k] == n - 1) m_wrap[k] = 1;
                    m_idx[k] = (m_idx[k] + 1) % n;
                end
            end
        end
        m_prev[k] = md ? 1 : 0;
    endfunction

    function automatic logic [63:0] exp_y(input int k);
        int n;
        logic [63:0] mask, v;
        n    = 1 << p_selw[k];
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        v    = (m_on[k] != 0) ? (64'd1 << m_idx[k]) : 64'd0;
        if (p_al[k] != 0) v = ~v & mask;
        return v;
    endfunction

    // Advance one clock, update both models, compare all outputs.
    task automatic cyc();
        @(posedge clk);
        model_edge(0, a_rst, a_en, a_mode, a_load, int'(a_sel));
        model_edge(1, b_rst, b_en, b_mode, b_load, int'(b_sel));
        #1;
        check_eq("a_y",    64'(y_a),    exp_y(0));
        check_eq("a_idx",  64'(idx_a),  64'(m_idx[0]));
        check_eq("a_wrap", 64'(wrap_a), 64'(m_wrap[0]));
        check_eq("b_y",    64'(y_b),    exp_y(1));
        check_eq("b_idx",  64'(idx_b),  64'(m_idx[1]));
        check_eq("b_wrap", 64'(wrap_b), 64'(m_wrap[1]));
        $display("t=%0t A: y=%b idx=%0d wrap=%0d | B: y=%b idx=%0d wrap=%0d",
                 $time, y_a, idx_a, wrap_a, y_b, idx_b, wrap_b);
    endtask

    task automatic set_a(input bit r, input bit e, input bit md, input bit ld,
                         input logic [1:0] s);
        a_rst = r; a_en = e; a_mode = md; a_load = ld; a_sel = s;
    endtask

    task automatic set_b(input bit r, input bit e, input bit md, input bit ld,
                         input logic [2:0] s);
        b_rst = r; b_en = e; b_mode = md; b_load = ld; b_sel = s;
    endtask

    initial begin
        set_a(1, 0, 0, 0, 2'd0);
        set_b(1, 0, 0, 0, 3'd0);

        // Reset held for two edges
        cyc();
        cyc();
        check_eq("rst_y",    64'(y_a),    64'h0);
        check_eq("rst_idx",  64'(idx_a),  64'h0);
        check_eq("rst_wrap", 64'(wrap_a), 64'h0);
        check_eq("rst_y_b",  64'(y_b),    64'hFF);

        // Direct decode with load, then hold while load is low
        set_a(0, 1, 0, 1, 2'd2);
        set_b(0, 0, 0, 0, 3'd0);
        cyc();
        check_eq("dir_y",   64'(y_a),   64'h4);
        check_eq("dir_idx", 64'(idx_a), 64'h2);
        set_a(0, 1, 0, 0, 2'd3);
        cyc();
        check_eq("dir_hold_y", 64'(y_a), 64'h4);

        // Scan from index 0 through one full wrap
        set_a(0, 1, 0, 1, 2'd0);
        cyc();
        set_a(0, 1, 1, 0, 2'd0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            check_eq("scan_y",    64'(y_a),    64'd1 << (i / 4));
            check_eq("scan_wrap", 64'(wrap_a), 64'h0);
        end
        cyc();
        check_eq("wrap_y",     64'(y_a),    64'h1);
        check_eq("wrap_pulse", 64'(wrap_a), 64'h1);
        cyc();
        check_eq("wrap_once",  64'(wrap_a), 64'h0);

        // Advance to idx=1 with two cycles already counted, then gate en
        for (int i = 0; i < 5; i++) cyc();
        a_en = 1'b0;
        cyc();
        check_eq("gap_y",   64'(y_a),   64'h0);
        check_eq("gap_idx", 64'(idx_a), 64'h1);
        a_en = 1'b1;
        cyc();
        check_eq("gap_resume_y", 64'(y_a), 64'h2);
        cyc();
        check_eq("gap_step_y",   64'(y_a), 64'h4);

        // Load on the step edge wins; then reset together with load
        for (int i = 0; i < 3; i++) cyc();
        set_a(0, 1, 1, 1, 2'd3);
        cyc();
        check_eq("ldstep_idx",  64'(idx_a),  64'h3);
        check_eq("ldstep_wrap", 64'(wrap_a), 64'h0);
        set_a(1, 1, 1, 1, 2'd2);
        cyc();
        check_eq("rstld_y",   64'(y_a),   64'h0);
        check_eq("rstld_idx", 64'(idx_a), 64'h0);

        // Instance B: one-cold decode and DIV=1 scan
        set_a(0, 0, 0, 0, 2'd0);
        set_b(0, 1, 0, 1, 3'd5);
        cyc();
        check_eq("b_load5_y", 64'(y_b), 64'hDF);
        set_b(0, 1, 0, 1, 3'd0);
        cyc();
        set_b(0, 1, 1, 0, 3'd0);
        cyc();
        for (int i = 1; i <= 16; i++) begin
            cyc();
            check_eq("b_scan_idx",  64'(idx_b),  64'(i % 8));
            check_eq("b_scan_wrap", 64'(wrap_b), 64'((i % 8) == 0));
        end

        // Randomized stimulus on both instances
        for (int i = 0; i < 400; i++) begin
            a_rst  = ($urandom_range(31) == 0);
            a_en   = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) a_mode = ~a_mode;
            a_load = ($urandom_range(7) == 0);
            a_sel  = 2'($urandom);
            b_rst  = ($urandom_range(31) == 0);
            b_en   = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) b_mode = ~b_mode;
            b_load = ($urandom_range(7) == 0);
            b_sel  = 3'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL provide parameter SEL_W, default 2, select width; output width is 2**SEL_W; legal 1..6.
REQ-002 SHALL provide parameter DIV, default 4, clock cycles per scan step; legal >= 1.
REQ-003 SHALL provide parameter ACT_LOW, default 0; 0 means active output bit is 1, 1 means active output bit is 0.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port en  input  1  output enable; 0 forces all outputs inactive.
REQ-007 SHALL provide port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 SHALL provide port load  input  1  strobe capturing sel into index register.
REQ-009 SHALL provide port sel  input  SEL_W  index to decode or scan start point.
REQ-010 SHALL provide port y  output  2**SEL_W  registered one-hot (or one-cold) decoded output.
REQ-011 SHALL provide port idx  output  SEL_W  current index register.
REQ-012 SHALL provide port wrap  output  1  one-cycle pulse when scan steps from 2**SEL_W-1 to 0.

Function
REQ-013 SHALL hold internal state: index register idx, step counter cnt (0..DIV-1), output register y, wrap register.
REQ-014 SHALL drive y with a 1-cycle registered latency: after any edge with en=1, y = decode(new idx); bit idx active, all others inactive.
REQ-015 SHALL define inactive as all-0 when ACT_LOW=0, all-1 when ACT_LOW=1.
REQ-016 SHALL, after an edge with en=0, drive y all inactive; idx and cnt hold; wrap=0.
REQ-017 SHALL, in direct mode (mode=0, en=1), load idx<=sel on load=1 and hold idx on load=0; cnt held at 0; wrap=0.
REQ-018 SHALL, in scan mode (mode=1, en=1, load=0), increment cnt each edge; when cnt==DIV-1, set cnt<=0 and idx<=idx+1 modulo 2**SEL_W.
REQ-019 SHALL assert wrap for exactly one cycle, coincident with y showing index 0, when the scan step moves idx from 2**SEL_W-1 to 0.
REQ-020 SHALL, in scan mode with load=1, load idx<=sel and cnt<=0 (load wins over step); no wrap pulse.
REQ-021 SHALL, with DIV=1, advance idx on every enabled scan-mode edge.
REQ-022 SHALL clear cnt to 0 on any edge where mode differs from its previous-cycle value; idx holds across mode change.
REQ-023 SHALL guarantee exactly one active y bit whenever the last edge had en=1 and rst=0.

Reset
REQ-024 SHALL, on an edge with rst=1, set idx=0, cnt=0, wrap=0, y all inactive, regardless of en, mode, load.
REQ-025 SHALL give rst priority over every other input, including mid-scan and simultaneous load.
REQ-026 SHALL require en=1 after reset before any active output appears; the first enabled edge shows decode(0) unless load applies.

Verification (SEL_W=2, DIV=4, ACT_LOW=0 unless stated)
REQ-027 SHALL cover reset: rst=1 for 2 edges -> y=0000, idx=0, wrap=0.
REQ-028 SHALL cover direct: en=1 mode=0 load=1 sel=2 -> next edge y=0100, idx=2; then load=0 sel=3 -> y stays 0100.
REQ-029 SHALL cover scan: from idx=0, mode=1 -> y=0001 4 cycles, 0010 4, 0100 4, 1000 4, then 0001 with wrap=1 for one cycle only.
REQ-030 SHALL cover enable gap: en=0 mid-scan at idx=1 cnt=2 -> y=0000 next edge; en=1 -> y=0010, step after 1 more cycle.
REQ-031 SHALL cover load-vs-step and reset: load=1 sel=3 on cnt=3 edge -> idx=3, no wrap; rst=1 with load=1 -> y=0000, idx=0.
REQ-032 SHALL cover parameters: SEL_W=3 ACT_LOW=1 load sel=5 -> y=11011111; DIV=1 scan -> idx increments every edge, wrap every 8 edges.
